// File: rtl/cmp_region_tracker_if.sv
// Comparator-flag input and committed-region status bundle for cmp_region_tracker.
// The master drives the flags and the counter clear; the slave (tracker) drives the status.
interface cmp_region_tracker_if #(parameter int CNT_W = 8);
  logic             cmp_valid;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;
  logic             clr_cnt;
  logic [1:0]       region;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] evt_cnt;
  logic             err;

  modport master (
    output cmp_valid, cmp_gt, cmp_lt, cmp_eq, clr_cnt,
    input  region, rise_pulse, fall_pulse, evt_cnt, err
  );

  modport slave (
    input  cmp_valid, cmp_gt, cmp_lt, cmp_eq, clr_cnt,
    output region, rise_pulse, fall_pulse, evt_cnt, err
  );
endinterface

// File: rtl/cmp_region_tracker.sv
// Debounced region tracker for a 4-bit comparator's gt/lt/eq flags, with crossing pulses and a saturating event counter.
// Optional macro CMP_FLAG_CHECK_EN: reject non-one-hot flags and raise a sticky err; otherwise decode gt>lt>eq.
//
// state | meaning
// IDLE  | nothing committed since reset
// BELOW | comparator input committed below the reference
// EQUAL | comparator input committed equal to the reference
// ABOVE | comparator input committed above the reference
module cmp_region_tracker #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cmp_region_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BELOW = 2'b01,
    EQUAL = 2'b10,
    ABOVE = 2'b11
  } region_t;

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  region_t          region_q, region_d;
  region_t          cand_q, cand_d;
  region_t          samp;
  logic [3:0]       run_q, run_d, run_upd;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flags_ok;

  always_comb begin
`ifdef CMP_FLAG_CHECK_EN
    flags_ok = ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} == 3'b100) ||
               ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} == 3'b010) ||
               ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} == 3'b001);
`else
    flags_ok = bus.cmp_gt | bus.cmp_lt | bus.cmp_eq;
`endif
    if (bus.cmp_gt)      samp = ABOVE;
    else if (bus.cmp_lt) samp = BELOW;
    else                 samp = EQUAL;
  end

  always_comb begin
    region_d = region_q;
    cand_d   = cand_q;
    run_d    = run_q;
    run_upd  = run_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    cnt_d    = cnt_q;
    if (bus.cmp_valid) begin
      if (!flags_ok) begin
        run_d = 4'd0;
      end else begin
        if (samp == region_q) begin
          run_upd = 4'd0;
        end else if (samp == cand_q) begin
          run_upd = run_q + 4'd1;
        end else begin
          cand_d  = samp;
          run_upd = 4'd1;
        end
        run_d = run_upd;
        // Commit on the same edge the run reaches the debounce length.
        if (run_upd == DB) begin
          region_d = cand_d;
          run_d    = 4'd0;
          rise_d   = (cand_d == ABOVE) && ((region_q == BELOW) || (region_q == EQUAL));
          fall_d   = (cand_d == BELOW) && ((region_q == ABOVE) || (region_q == EQUAL));
        end
      end
    end
    if (bus.clr_cnt)
      cnt_d = '0;
    else if ((rise_d || fall_d) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_q <= IDLE;
      cand_q   <= IDLE;
      run_q    <= 4'd0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      region_q <= region_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef CMP_FLAG_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (bus.cmp_valid && !flags_ok)
      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.region     = region_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.evt_cnt    = cnt_q;

endmodule

// File: doc/cmp_region_tracker.md
CMP_REGION_TRACKER -- requirements
Module: cmp_region_tracker

Interface
REQ-001 Parameter DEBOUNCE, default 3, sets the consecutive valid samples (1..15) needed to commit a region change.
REQ-002 Parameter CNT_W, default 8, sets the width of the crossing-event counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 cmp_valid  input  1  comparator flags are valid this cycle.
REQ-006 cmp_gt  input  1  upstream 4-bit comparator a_greater flag.
REQ-007 cmp_lt  input  1  upstream 4-bit comparator a_less flag.
REQ-008 cmp_eq  input  1  upstream 4-bit comparator a_equal_b flag.
REQ-009 clr_cnt  input  1  synchronous clear of the event counter.
REQ-010 region  output  2  committed region: 00 IDLE, 01 BELOW, 10 EQUAL, 11 ABOVE.
REQ-011 rise_pulse  output  1  one-cycle pulse on a committed entry into ABOVE from BELOW or EQUAL.
REQ-012 fall_pulse  output  1  one-cycle pulse on a committed entry into BELOW from ABOVE or EQUAL.
REQ-013 evt_cnt  output  CNT_W  count of rise and fall pulses, saturating.
REQ-014 err  output  1  sticky flag for malformed flags.

Function
REQ-015 A sample is accepted on a rising edge where cmp_valid=1; all other cycles leave every register unchanged except pulses and the clr_cnt effect.
REQ-016 Sample region decode: gt→ABOVE, lt→BELOW, eq→EQUAL; the flags are well-formed only when exactly one is set.
REQ-017 A state register holds the committed region. A candidate register and a run counter (0..DEBOUNCE) track the pending region.
REQ-018 Accepted sample equal to the committed region: the run counter clears to 0.
REQ-019 Accepted sample equal to the candidate but not the committed region: the run counter increments.
REQ-020 Otherwise: the candidate becomes the sample region and the run counter becomes 1.
REQ-021 When the updated run equals DEBOUNCE, on that same edge: region takes the candidate value and the run clears to 0.
REQ-022 A commit drives rise_pulse or fall_pulse high for exactly the following cycle, following REQ-011/012.
REQ-023 Commits into EQUAL, and any commit out of IDLE, produce no pulse.
REQ-024 With DEBOUNCE=1, every accepted sample differing from the committed region commits immediately.
REQ-025 evt_cnt increments by 1 per pulse.
REQ-026 evt_cnt holds at 2^CNT_W-1.
REQ-027 clr_cnt=1 sets evt_cnt to 0 and takes priority over a simultaneous increment.
REQ-028 Malformed flags with cmp_valid=1: the sample is discarded and the run counter clears to 0 (see Configuration).
REQ-029 Flags with cmp_valid=0 are ignored regardless of value.

Reset
REQ-030 rst_n low asynchronously forces the following values: region=00 (IDLE), candidate=IDLE, run=0, rise_pulse=0, fall_pulse=0, evt_cnt=0, err=0.
REQ-031 Reset asserted mid-run discards the pending candidate.
REQ-032 No pulse is generated on reset release.

Configuration
REQ-033 Macro CMP_FLAG_CHECK_EN defined: malformed flags are handled per REQ-028 and set err high until reset.
REQ-034 Macro CMP_FLAG_CHECK_EN undefined: flags are decoded by priority gt>lt>eq, an all-zero sample is discarded per REQ-028, and err is tied to 0.

Verification (DEBOUNCE=3, CNT_W=8)
REQ-035 Release reset, then apply 3 valid lt samples → region=01 after the 3rd edge; no pulse; evt_cnt=0.
REQ-036 From BELOW, apply gt,gt,lt,gt,gt,gt → commit only after the final gt; region=11; rise_pulse high one cycle; evt_cnt=1.
REQ-037 From ABOVE, apply gt,gt with cmp_valid toggling 1,0,1,0,1 → no commit; region stays 11.
REQ-038 Force evt_cnt to 255, then trigger a fall → evt_cnt stays 255. Then assert clr_cnt in the same cycle as a pulse → evt_cnt=0.
REQ-039 With CMP_FLAG_CHECK_EN defined, apply gt=1, lt=1, valid=1 → err=1 and the run clears. With the macro undefined, the same stimulus counts as ABOVE and err=0.
REQ-040 Deassert rst_n after 2 of 3 pending gt samples → outputs return to reset values immediately; a single gt after release does not commit.
